potato1_datapath: RTL

Downstream execution stage for the Potato-1 control core. It consumes the 8-bit command byte the core emits and owns all architectural state: program counter, data pointer X, data cell memory, and the PUT/GET I/O handshakes. It returns the next instruction nibble, the zero flag and the I/O-wait flag, which the core samples on its io_in[7:4], io_in[3] and io_in[2].

---
 rtl/potato1_datapath.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/potato1_datapath.sv
// Potato-1 execution datapath: PC, data pointer, cell memory and PUT/GET handshakes.
// Consumes the core's command byte and returns instruction nibble, zero and wait flags.
module potato1_datapath #(
    parameter int PC_WIDTH   = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [7:0]            Cmd_In,
    output logic [PC_WIDTH-1:0]   Prog_Addr,
    input  logic [3:0]            Prog_Data,
    output logic [3:0]            Instr_Out,
    output logic                  Zero_Out,
    output logic                  Wait_Out,
    output logic [DATA_WIDTH-1:0] Out_Data,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    input  logic [DATA_WIDTH-1:0] In_Data,
    input  logic                  In_Valid,
    output logic                  In_Ready,
    output logic                  Cmd_Err
);

    localparam int XW = $clog2(DATA_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        PUT_WAIT,
        GET_WAIT,
        RELEASE
    } state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [XW-1:0]         x_q, x_d;
    logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DATA_DEPTH];
    logic [3:0]            instr_q, instr_d;
    logic                  zero_q, zero_d;
    logic                  wait_q, wait_d;
    logic [DATA_WIDTH-1:0] odata_q, odata_d;
    logic                  ovalid_q, ovalid_d;
    logic                  iready_q, iready_d;
    logic                  err_q, err_d;

    logic pc_inc, pc_dec, x_inc, x_dec, a_inc, a_dec, put, get;

    assign {get, put, a_dec, a_inc, x_dec, x_inc, pc_dec, pc_inc} = Cmd_In;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        x_d      = x_q;
        mem_d    = mem_q;
        instr_d  = Prog_Data;
        zero_d   = zero_q;
        wait_d   = wait_q;
        odata_d  = odata_q;
        ovalid_d = ovalid_q;
        iready_d = iready_q;
        err_d    = err_q;

        unique case (state_q)
            IDLE, RELEASE: begin
                if (pc_inc && pc_dec)  err_d = 1'b1;
                else if (pc_inc)       pc_d  = pc_q + 1'b1;
                else if (pc_dec)       pc_d  = pc_q - 1'b1;

                if (x_inc && x_dec)    err_d = 1'b1;
                else if (x_inc)        x_d   = x_q + 1'b1;
                else if (x_dec)        x_d   = x_q - 1'b1;

                // Cell update addresses the pointer as it was before this edge
                if (a_inc && a_dec)    err_d = 1'b1;
                else if (a_inc)        mem_d[x_q] = mem_q[x_q] + 1'b1;
                else if (a_dec)        mem_d[x_q] = mem_q[x_q] - 1'b1;

                zero_d = (mem_d[x_d] == '0);

                if (state_q == RELEASE) begin
                    state_d = IDLE;
                end else if (put && get) begin
                    err_d = 1'b1;
                end else if (put) begin
                    odata_d  = mem_d[x_q];
                    ovalid_d = 1'b1;
                    wait_d   = 1'b1;
                    state_d  = PUT_WAIT;
                end else if (get) begin
                    iready_d = 1'b1;
                    wait_d   = 1'b1;
                    state_d  = GET_WAIT;
                end
            end
            PUT_WAIT: begin
                if (ovalid_q && Out_Ready) begin
                    ovalid_d = 1'b0;
                    wait_d   = 1'b0;
                    state_d  = RELEASE;
                end
            end
            GET_WAIT: begin
                if (In_Valid && iready_q) begin
                    mem_d[x_q] = In_Data;
                    zero_d     = (In_Data == '0);
                    iready_d   = 1'b0;
                    wait_d     = 1'b0;
                    state_d    = RELEASE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            x_q      <= '0;
            for (int i = 0; i < DATA_DEPTH; i++) mem_q[i] <= '0;
            instr_q  <= 4'b1111;
            zero_q   <= 1'b1;
            wait_q   <= 1'b0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            iready_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            x_q      <= x_d;
            mem_q    <= mem_d;
            instr_q  <= instr_d;
            zero_q   <= zero_d;
            wait_q   <= wait_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            iready_q <= iready_d;
            err_q    <= err_d;
        end
    end

    assign Prog_Addr = pc_q;
    assign Instr_Out = instr_q;
    assign Zero_Out  = zero_q;
    assign Wait_Out  = wait_q;
    assign Out_Data  = odata_q;
    assign Out_Valid = ovalid_q;
    assign In_Ready  = iready_q;
    assign Cmd_Err   = err_q;

endmodule
